// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard/stall controller: FSM states,
// register-index width, and the bundled set of stage control enables.
package pipe_pkg;

  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t XZR_IDX = 5'd31;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_write;
    logic exmem_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_bubble;
    logic pc_src_branch;
  } ctrl_t;

  localparam ctrl_t CTRL_DEFAULT = '{pc_write: 1'b1, ifid_write: 1'b1, idex_write: 1'b1,
                                     exmem_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                                     exmem_flush: 1'b0, memwb_bubble: 1'b0, pc_src_branch: 1'b0};

  // Whole front end frozen; MEM/WB receives a bubble while the access is outstanding.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, idex_write: 1'b0,
                                    exmem_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0,
                                    exmem_flush: 1'b0, memwb_bubble: 1'b1, pc_src_branch: 1'b0};

  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b1, idex_write: 1'b1,
                                   exmem_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1,
                                   exmem_flush: 1'b1, memwb_bubble: 1'b1, pc_src_branch: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard-controller bus: pipeline status into the controller, stage
// enables/flushes and statistics back out.
interface pipeline_ctrl_if
  import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) ();

    reg_idx_t         id_rs1;
    reg_idx_t         id_rs2;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    reg_idx_t         ex_rd;
    logic             mem_branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             ifid_write;
    logic             idex_write;
    logic             exmem_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic             pc_src_branch;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [15:0]      flush_count;

    modport master (
        output id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               mem_branch_taken, dmem_req, dmem_ready,
        input  pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               pc_src_branch, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd,
               mem_branch_taken, dmem_req, dmem_ready,
        output pc_write, ifid_write, idex_write, exmem_write,
               ifid_flush, idex_flush, exmem_flush, memwb_bubble,
               pc_src_branch, mem_timeout, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard comparator: a load in EX whose destination feeds the
// instruction in ID. The zero register never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
(
    input  logic     ex_mem_read_i,
    input  reg_idx_t ex_rd_i,
    input  reg_idx_t id_rs1_i,
    input  reg_idx_t id_rs2_i,
    input  logic     id_uses_rs2_i,
    output logic     hazard_o
);

    logic rs1_match;
    logic rs2_match;

    assign rs1_match = (ex_rd_i == id_rs1_i);
    assign rs2_match = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
    assign hazard_o  = ex_mem_read_i && (ex_rd_i != XZR_IDX) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: branch flushes, data-memory wait freeze
// with timeout abort, load-use stalls, and saturating event counters.
module pipeline_ctrl
  import pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    pipeline_ctrl_if.slave   ctrl_bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_q;
    logic [15:0]       flush_q;
    logic              timeout_q;

    logic  load_use;
    logic  stall_inc;
    logic  flush_inc;
    logic  timeout_set;
    ctrl_t ctrl;

    function automatic logic [CNT_W-1:0] sat_inc_stall(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [15:0] sat_inc_flush(input logic [15:0] v);
        return (v == '1) ? v : v + 16'd1;
    endfunction

    hazard_detect u_hazard (
        .ex_mem_read_i (ctrl_bus.ex_mem_read),
        .ex_rd_i       (ctrl_bus.ex_rd),
        .id_rs1_i      (ctrl_bus.id_rs1),
        .id_rs2_i      (ctrl_bus.id_rs2),
        .id_uses_rs2_i (ctrl_bus.id_uses_rs2),
        .hazard_o      (load_use)
    );

    always_comb begin
        ctrl        = CTRL_DEFAULT;
        state_d     = state_q;
        wait_d      = wait_q;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        timeout_set = 1'b0;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else begin
            case (state_q)
                RUN: begin
                    if (ctrl_bus.mem_branch_taken) begin
                        ctrl.pc_src_branch = 1'b1;
                        ctrl.ifid_flush    = 1'b1;
                        ctrl.idex_flush    = 1'b1;
                        ctrl.exmem_flush   = 1'b1;
                        flush_inc          = 1'b1;
                    end else if (ctrl_bus.dmem_req && !ctrl_bus.dmem_ready) begin
                        ctrl      = CTRL_FREEZE;
                        state_d   = MEM_WAIT;
                        wait_d    = '0;
                        stall_inc = 1'b1;
                    end else if (load_use) begin
                        ctrl.pc_write   = 1'b0;
                        ctrl.ifid_write = 1'b0;
                        ctrl.idex_flush = 1'b1;
                        stall_inc       = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    // Hazards and branches are not looked at here: the frozen stages hold them.
                    if (ctrl_bus.dmem_ready) begin
                        state_d = RUN;
                        wait_d  = '0;
                    end else if (wait_q == WAIT_LIMIT) begin
                        ctrl.exmem_flush = 1'b1;
                        timeout_set      = 1'b1;
                        state_d          = RUN;
                        wait_d           = '0;
                    end else begin
                        ctrl      = CTRL_FREEZE;
                        wait_d    = wait_q + WAIT_W'(1);
                        stall_inc = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            wait_q    <= '0;
            stall_q   <= '0;
            flush_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_q | timeout_set;
            if (stall_inc) stall_q <= sat_inc_stall(stall_q);
            if (flush_inc) flush_q <= sat_inc_flush(flush_q);
        end
    end

    assign ctrl_bus.pc_write      = ctrl.pc_write;
    assign ctrl_bus.ifid_write    = ctrl.ifid_write;
    assign ctrl_bus.idex_write    = ctrl.idex_write;
    assign ctrl_bus.exmem_write   = ctrl.exmem_write;
    assign ctrl_bus.ifid_flush    = ctrl.ifid_flush;
    assign ctrl_bus.idex_flush    = ctrl.idex_flush;
    assign ctrl_bus.exmem_flush   = ctrl.exmem_flush;
    assign ctrl_bus.memwb_bubble  = ctrl.memwb_bubble;
    assign ctrl_bus.pc_src_branch = ctrl.pc_src_branch;
    assign ctrl_bus.mem_timeout   = timeout_q;
    assign ctrl_bus.stall_cycles  = stall_q;
    assign ctrl_bus.flush_count   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios then random traffic, all
// compared cycle by cycle against a behavioural model of the control rules.
module tb_pipeline_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    // {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, exmem_flush, memwb_bubble, pc_src_branch}
    localparam logic [8:0] E_DEF = 9'b1_1_1_1_0_0_0_0_0;
    localparam logic [8:0] E_RST = 9'b0_1_1_1_1_1_1_1_0;
    localparam logic [8:0] E_BR  = 9'b1_1_1_1_1_1_1_0_1;
    localparam logic [8:0] E_FRZ = 9'b0_0_0_0_0_0_0_1_0;
    localparam logic [8:0] E_LU  = 9'b0_0_1_1_0_1_0_0_0;
    localparam logic [8:0] E_TMO = 9'b1_1_1_1_0_0_1_0_0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    pipeline_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .ctrl_bus (bus)
    );

    wire [8:0] obs_ctrl = {bus.pc_write, bus.ifid_write, bus.idex_write, bus.exmem_write,
                           bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_bubble,
                           bus.pc_src_branch};

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Model: a memory access is either outstanding (with a count of extra wait cycles) or not.
    bit m_waiting = 1'b0;
    int m_waited  = 0;
    int m_stall   = 0;
    int m_flush   = 0;
    bit m_abort   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                          input logic mr, input logic [4:0] rd, input logic br,
                          input logic rq, input logic rdy);
        bus.id_rs1           = rs1;
        bus.id_rs2           = rs2;
        bus.id_uses_rs2      = u2;
        bus.ex_mem_read      = mr;
        bus.ex_rd            = rd;
        bus.mem_branch_taken = br;
        bus.dmem_req         = rq;
        bus.dmem_ready       = rdy;
    endtask

    function automatic int bump(input int v, input int max);
        return (v < max) ? v + 1 : max;
    endfunction

    task automatic cycle(input string tag);
        logic [8:0] e;
        bit dep;
        @(negedge clock);
        dep = bus.ex_mem_read && (bus.ex_rd != 5'd31) &&
              ((bus.ex_rd == bus.id_rs1) || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
        e = E_DEF;
        if (reset) e = E_RST;
        else if (!m_waiting) begin
            if (bus.mem_branch_taken) e = E_BR;
            else if (bus.dmem_req && !bus.dmem_ready) e = E_FRZ;
            else if (dep) e = E_LU;
        end else begin
            if (bus.dmem_ready) e = E_DEF;
            else if (m_waited == TO) e = E_TMO;
            else e = E_FRZ;
        end
        check({tag, ".ctrl"}, 32'(obs_ctrl), 32'(e));
        check({tag, ".timeout"}, 32'(bus.mem_timeout), 32'(m_abort));
        check({tag, ".stalls"}, 32'(bus.stall_cycles), m_stall);
        check({tag, ".flushes"}, 32'(bus.flush_count), m_flush);
        if (reset) begin
            m_waiting = 1'b0; m_waited = 0; m_stall = 0; m_flush = 0; m_abort = 1'b0;
        end else if (!m_waiting) begin
            if (bus.mem_branch_taken) m_flush = bump(m_flush, 65535);
            else if (bus.dmem_req && !bus.dmem_ready) begin
                m_waiting = 1'b1; m_waited = 0; m_stall = bump(m_stall, CMAX);
            end else if (dep) m_stall = bump(m_stall, CMAX);
        end else begin
            if (bus.dmem_ready) m_waiting = 1'b0;
            else if (m_waited == TO) begin
                m_waiting = 1'b0; m_abort = 1'b1;
            end else begin
                m_waited++; m_stall = bump(m_stall, CMAX);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("reset");
        reset = 1'b0;
    endtask

    function automatic logic [4:0] rreg();
        int k;
        k = int'($urandom_range(0, 4));
        return (k == 4) ? 5'd31 : 5'(k);
    endfunction

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        cycle("reset0");
        reset = 1'b0;
        cycle("idle");

        // Load-use on rs1, then the zero register, then rs2 with/without use.
        set_in(3, 0, 0, 1, 3, 0, 0, 0); cycle("lu_rs1");
        set_in(3, 0, 0, 0, 3, 0, 0, 0); cycle("lu_done");
        check("lu_stall_count", 32'(bus.stall_cycles), 1);
        set_in(31, 0, 0, 1, 31, 0, 0, 0); cycle("lu_xzr");
        check("xzr_no_stall", 32'(bus.stall_cycles), 1);
        set_in(1, 5, 0, 1, 5, 0, 0, 0); cycle("rs2_unused");
        set_in(1, 5, 1, 1, 5, 0, 0, 0); cycle("rs2_used");
        check("rs2_stall_count", 32'(bus.stall_cycles), 2);

        // Four-cycle memory wait then release.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) cycle("mwait");
        set_in(0, 0, 0, 0, 0, 0, 1, 1); cycle("mrelease");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("mafter");
        check("mwait_stalls", 32'(bus.stall_cycles), 4);
        check("mwait_run", 32'(obs_ctrl), 32'(E_DEF));

        // Branch beats a simultaneous load-use.
        do_reset();
        set_in(3, 0, 0, 1, 3, 1, 1, 0); cycle("br_lu");
        set_in(0, 0, 0, 0, 0, 0, 0, 0); cycle("br_after");
        check("br_flush_count", 32'(bus.flush_count), 1);
        check("br_no_stall", 32'(bus.stall_cycles), 0);

        // Wait timeout: entry, four counted waits, abort cycle.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cycle("tmo_wait");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("tmo_after");
        check("tmo_sticky", 32'(bus.mem_timeout), 1);
        check("tmo_stalls", 32'(bus.stall_cycles), 5);

        // Reset during the second wait cycle.
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 1, 0);
        cycle("rmid_entry");
        cycle("rmid_wait1");
        reset = 1'b1;
        cycle("rmid_reset");
        reset = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycle("rmid_after");
        check("rmid_stalls", 32'(bus.stall_cycles), 0);
        check("rmid_timeout", 32'(bus.mem_timeout), 0);

        // Saturation of the stall counter.
        do_reset();
        set_in(3, 0, 0, 1, 3, 0, 0, 0);
        for (int i = 0; i < 20; i++) cycle("sat");
        check("sat_stalls", 32'(bus.stall_cycles), 15);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            set_in(rreg(), rreg(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rreg(),
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 4) == 0));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255, max MEM_WAIT cycles before abort.
REQ-002 SHALL have parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 id_rs1, id_rs2  input  5 each  source registers of the instruction in ID.
REQ-006 id_uses_rs2  input  1  ID instruction reads id_rs2.
REQ-007 ex_mem_read  input  1  EX-stage instruction is a load.
REQ-008 ex_rd  input  5  destination register of the EX-stage instruction.
REQ-009 mem_branch_taken  input  1  branch resolved taken in MEM (branch and zero).
REQ-010 dmem_req, dmem_ready  input  1 each  MEM-stage access valid; data memory done.
REQ-011 pc_write, ifid_write, idex_write, exmem_write  output  1 each  register load enables.
REQ-012 ifid_flush, idex_flush, exmem_flush, memwb_bubble  output  1 each  zero the stage on the next edge.
REQ-013 pc_src_branch  output  1  PC loads the branch target.
REQ-014 mem_timeout  output  1  sticky abort flag.
REQ-015 stall_cycles  output  CNT_W  saturating count of freeze and load-use cycles.
REQ-016 flush_count  output  16  saturating count of taken-branch flushes.

Function
REQ-017 SHALL implement FSM states RUN and MEM_WAIT; control outputs SHALL be combinational from state and inputs.
REQ-018 Defaults (RUN, no event): all write enables 1, all flushes and bubble 0, pc_src_branch 0.
REQ-019 Priority in RUN: branch > memory wait > load-use.
REQ-020 Branch (RUN, mem_branch_taken=1): pc_src_branch=1, pc_write=1, ifid_flush=idex_flush=exmem_flush=1, ignore dmem_req, no load-use stall, flush_count+1.
REQ-021 Memory wait entry (RUN, dmem_req=1, dmem_ready=0): pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, next state MEM_WAIT, stall_cycles+1.
REQ-022 (RUN, dmem_req=1, dmem_ready=1): access completes with no stall, default outputs.
REQ-023 MEM_WAIT with dmem_ready=0: same freeze outputs as REQ-021, wait counter+1, stall_cycles+1.
REQ-024 MEM_WAIT with dmem_ready=1: default outputs (release), next state RUN, wait counter cleared.
REQ-025 Timeout: if the wait counter equals MEM_TIMEOUT while dmem_ready=0, set mem_timeout, flush exmem (exmem_flush=1, exmem_write=1), release all other stages, and return to RUN.
REQ-026 Load-use (RUN, no branch or wait): ex_mem_read=1, ex_rd!=31, ex_rd==id_rs1 or (id_uses_rs2 and ex_rd==id_rs2) gives pc_write=0, ifid_write=0, idex_flush=1, stall_cycles+1.
REQ-027 Register 31 (XZR) SHALL never cause a load-use stall.
REQ-028 Load-use hazards SHALL NOT be evaluated in MEM_WAIT; the frozen pipeline holds the hazard until release.
REQ-029 Counters SHALL saturate at all-ones and never wrap.
REQ-030 mem_timeout SHALL stay at 1 until reset.

Reset
REQ-031 On a clock edge with reset=1: state becomes RUN; wait counter, stall_cycles, flush_count and mem_timeout become 0.
REQ-032 While reset=1: pc_write=0, all flushes and memwb_bubble=1, other write enables 1, pc_src_branch=0.
REQ-033 Reset asserted in MEM_WAIT SHALL abort the wait immediately, with no timeout flag.

Structure
REQ-034 Shared package pipe_pkg SHALL hold the state enum (RUN, MEM_WAIT), XZR_IDX=5'd31, and the register-index width.
REQ-035 Load-use comparison SHALL be a sub-module hazard_detect (purely combinational); the FSM, counters and output muxing SHALL stay in pipeline_ctrl.

Verification
REQ-036 Load-use: ex_mem_read=1, ex_rd=3, id_rs1=3 gives 1 cycle of pc_write=0, idex_flush=1, stall_cycles=1; with ex_rd=31 there is no stall.
REQ-037 Memory wait: dmem_req=1, dmem_ready low for 4 cycles then high gives freeze for 4 cycles, release on the 5th, stall_cycles=4, state RUN.
REQ-038 Branch and load-use together: mem_branch_taken=1 with a load-use match gives three flushes, pc_src_branch=1, pc_write=1, flush_count=1, stall_cycles unchanged.
REQ-039 Timeout: MEM_TIMEOUT=4, dmem_ready held 0 gives mem_timeout=1 after the wait counter reaches 4, exmem_flush pulsed, RUN resumed, flag sticky.
REQ-040 Reset mid-wait: reset pulsed in the 2nd MEM_WAIT cycle gives state RUN, counters 0, mem_timeout 0, flush outputs 1 during reset.
REQ-041 Saturation: CNT_W=4 with 20 stall cycles leaves stall_cycles at 15.
